// File: rtl/i2s_tx_serializer_if.sv
// Bundle between the I2S TX serializer and its register block / TX FIFOs.
// master = serializer side (consumes FIFO heads, drives the I2S pins and status).
// slave  = environment side (FIFOs, command register, pad logic).
interface i2s_tx_serializer_if #(
  parameter int DATA_W = 32
);
  logic              i2s_enable;
  logic              fifol_empty;
  logic [DATA_W-1:0] fifol_rdata;
  logic              fifol_rd;
  logic              fifor_empty;
  logic [DATA_W-1:0] fifor_rdata;
  logic              fifor_rd;
  logic              i2s_sck;
  logic              i2s_ws;
  logic              i2s_sd;
  logic              underrun;
  logic              busy;

  modport master (
    input  i2s_enable, fifol_empty, fifol_rdata, fifor_empty, fifor_rdata,
    output fifol_rd, fifor_rd, i2s_sck, i2s_ws, i2s_sd, underrun, busy
  );

  modport slave (
    output i2s_enable, fifol_empty, fifol_rdata, fifor_empty, fifor_rdata,
    input  fifol_rd, fifor_rd, i2s_sck, i2s_ws, i2s_sd, underrun, busy
  );
endinterface

// File: rtl/i2s_tx_serializer.sv
// Philips-format I2S master transmitter: pops L/R sample pairs from two FWFT FIFOs and shifts them out MSB first.
// Latency: pop at t, first SCK rise at t+CLK_DIV, first data bit on SD at t+2*CLK_DIV; one frame = 4*DATA_W*CLK_DIV clk.
// Backpressure: pops only when both FIFOs hold a word; an empty FIFO at a frame boundary sends a zero frame and pulses underrun.
module i2s_tx_serializer #(
  parameter int DATA_W  = 32,
  parameter int CLK_DIV = 4
) (
  input logic                 clk,
  input logic                 rst,
  i2s_tx_serializer_if.master bus
);
  localparam int FRAME_BITS = 2 * DATA_W;
  localparam int BIT_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_BITS - 1);
  localparam logic [BIT_W-1:0] WS_FIRST = BIT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shreg;
  logic                  draining;
  logic                  sck;
  logic                  ws;
  logic                  sd;
  logic                  busy;
  logic                  pop;
  logic                  urun;
  logic                  pair_ready;

  // Both heads must be valid so the left and right channels never slip apart.
  assign pair_ready = !bus.fifol_empty && !bus.fifor_empty;

  assign bus.fifol_rd = pop;
  assign bus.fifor_rd = pop;
  assign bus.i2s_sck  = sck;
  assign bus.i2s_ws   = ws;
  assign bus.i2s_sd   = sd;
  assign bus.underrun = urun;
  assign bus.busy     = busy;

  // Control FSM, SCK divider and shifter; every output is a flop.
  // When disabled at a boundary, the R LSB still needs the SCK rise that
  // follows it, so the block drains for one more half period and drops to
  // IDLE on the following falling edge (where SCK and WS are already low).
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      draining <= 1'b0;
      sck      <= 1'b0;
      ws       <= 1'b0;
      sd       <= 1'b0;
      busy     <= 1'b0;
      pop      <= 1'b0;
      urun     <= 1'b0;
    end else begin
      pop  <= 1'b0;
      urun <= 1'b0;
      case (state)
        IDLE: begin
          sck  <= 1'b0;
          ws   <= 1'b0;
          sd   <= 1'b0;
          busy <= 1'b0;
          if (bus.i2s_enable && pair_ready) begin
            pop      <= 1'b1;
            shreg    <= {bus.fifol_rdata, bus.fifor_rdata};
            bit_cnt  <= '0;
            div_cnt  <= '0;
            draining <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            sck     <= ~sck;
            if (sck) begin
              // Falling SCK edge: SD/WS only ever change here.
              if (draining) begin
                draining <= 1'b0;
                sd       <= 1'b0;
                ws       <= 1'b0;
                busy     <= 1'b0;
                bit_cnt  <= '0;
                state    <= IDLE;
              end else begin
                sd <= shreg[FRAME_BITS-1];
                ws <= (bit_cnt >= WS_FIRST) && (bit_cnt != LAST_BIT);
                if (bit_cnt == LAST_BIT) begin
                  bit_cnt <= '0;
                  if (!bus.i2s_enable) begin
                    shreg    <= '0;
                    draining <= 1'b1;
                  end else if (pair_ready) begin
                    pop   <= 1'b1;
                    shreg <= {bus.fifol_rdata, bus.fifor_rdata};
                  end else begin
                    urun  <= 1'b1;
                    shreg <= '0;
                  end
                end else begin
                  bit_cnt <= bit_cnt + BIT_W'(1);
                  shreg   <= {shreg[FRAME_BITS-2:0], 1'b0};
                end
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
